// File: rtl/minifloat_block_accumulator.sv
// Expands 4-bit mantissa / 3-bit exponent minifloat samples back to integers and
// sums them over fixed-length (or flushed) blocks, emitting one result per block.
module minifloat_block_accumulator #(
    parameter int ACC_W     = 16,
    parameter int BLOCK_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_m,
    input  logic [2:0]       in_e,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state, state_next;
    logic [ACC_W-1:0] acc, acc_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sat, sat_next;
    logic [10:0]      value;
    logic [ACC_W:0]   sum_wide;
    logic             accept;
    logic             close;

    assign in_ready = (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign sum_wide = {1'b0, acc} + (ACC_W+1)'(value);

    // Hidden leading one is restored for every non-zero exponent.
    always_comb begin
        value = 11'(in_m);
        if (in_e != 3'd0)
            value = 11'({1'b1, in_m}) << (in_e - 3'd1);
    end

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        acc_next   = acc;
        cnt_next   = cnt;
        sat_next   = sat;
        close      = 1'b0;
        case (state)
            ACCUM: begin
                if (accept) begin
                    acc_next = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
                    sat_next = sat | sum_wide[ACC_W];
                    cnt_next = cnt + CNT_W'(1);
                end
                // A flush on an empty block (no samples, none arriving) closes nothing.
                close = (accept && (cnt_next == CNT_W'(BLOCK_LEN))) ||
                        (flush && (cnt_next != '0));
                if (close)
                    state_next = HOLD;
            end
            HOLD: begin
                if (out_ready)
                    state_next = ACCUM;
            end
            default: state_next = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            state <= state_next;
            if (close) begin
                out_valid <= 1'b1;
                out_sum   <= acc_next;
                out_count <= cnt_next;
                out_sat   <= sat_next;
                acc       <= '0;
                cnt       <= '0;
                sat       <= 1'b0;
            end else if (state == ACCUM) begin
                acc <= acc_next;
                cnt <= cnt_next;
                sat <= sat_next;
            end
            if (state == HOLD && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_minifloat_block_accumulator.sv
// Drives two accumulators (ACC_W=16 and ACC_W=12) with shared stimulus and checks
// them every cycle against a transaction-level block-sum model.
module tb_minifloat_block_accumulator;

    localparam int BLOCK_LEN = 8;
    localparam int CNT_W     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_m = '0;
    logic [2:0]  in_e = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic             in_ready0, in_ready1;
    logic             out_valid0, out_valid1;
    logic [15:0]      out_sum0;
    logic [11:0]      out_sum1;
    logic [CNT_W-1:0] out_count0, out_count1;
    logic             out_sat0, out_sat1;

    always #5 clk = ~clk;

    minifloat_block_accumulator #(.ACC_W(16), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_m(in_m), .in_e(in_e), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_sum(out_sum0), .out_count(out_count0), .out_sat(out_sat0)
    );

    minifloat_block_accumulator #(.ACC_W(12), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_m(in_m), .in_e(in_e), .flush(flush), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sum(out_sum1), .out_count(out_count1), .out_sat(out_sat1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: one running block plus the last published result, per width.
    longint m_max [2] = '{65535, 4095};
    longint m_acc [2];
    bit     m_sat [2];
    int     m_cnt;
    bit     m_hold;
    longint m_osum[2];
    bit     m_osat[2];
    int     m_ocnt;
    bit     m_ov;
    bit     cmp_en = 1'b0;

    function automatic longint expand(input int m, input int e);
        return (e == 0) ? longint'(m) : longint'((16 + m) * (1 << (e - 1)));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_sat[k] = 0; m_osum[k] = 0; m_osat[k] = 0;
        end
        m_cnt = 0; m_ocnt = 0; m_hold = 0; m_ov = 0;
    endtask

    // Effect of one clock edge on the model, given the inputs held across it.
    task automatic model_edge(input bit v, input int m, input int e, input bit fl, input bit ordy);
        bit took;
        if (m_hold) begin
            if (ordy) begin
                m_hold = 0;
                m_ov   = 0;
            end
            return;
        end
        took = v;
        if (took) begin
            for (int k = 0; k < 2; k++) begin
                m_acc[k] += expand(m, e);
                if (m_acc[k] > m_max[k]) begin
                    m_acc[k] = m_max[k];
                    m_sat[k] = 1;
                end
            end
            m_cnt++;
        end
        if ((took && m_cnt == BLOCK_LEN) || (fl && m_cnt != 0)) begin
            for (int k = 0; k < 2; k++) begin
                m_osum[k] = m_acc[k]; m_osat[k] = m_sat[k];
                m_acc[k]  = 0;        m_sat[k]  = 0;
            end
            m_ocnt = m_cnt; m_cnt = 0;
            m_ov = 1; m_hold = 1;
        end
    endtask

    // One cycle: drive at the falling edge, advance the model to the post-edge state.
    task automatic cyc(input bit v, input int m, input int e, input bit fl, input bit ordy, input bit r);
        @(negedge clk);
        in_valid  = v;
        in_m      = 4'(m);
        in_e      = 3'(e);
        flush     = fl;
        out_ready = ordy;
        rst       = r;
        if (r) model_reset();
        else   model_edge(v, m, e, fl, ordy);
    endtask

    // Offer a sample until the model says the block takes it.
    task automatic send(input int m, input int e, input bit fl, input bit ordy);
        bit done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            done = !m_hold;
            cyc(1, m, e, fl, ordy, 0);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("in_ready0",  in_ready0,  !m_hold);
            check("in_ready1",  in_ready1,  !m_hold);
            check("out_valid0", out_valid0, m_ov);
            check("out_valid1", out_valid1, m_ov);
            check("out_count0", out_count0, m_ocnt);
            check("out_count1", out_count1, m_ocnt);
            check("out_sum0",   out_sum0,   m_osum[0]);
            check("out_sum1",   out_sum1,   m_osum[1]);
            check("out_sat0",   out_sat0,   m_osat[0]);
            check("out_sat1",   out_sat1,   m_osat[1]);
        end
    end

    initial begin
        cyc(0, 0, 0, 0, 1, 1);
        cmp_en = 1'b1;
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 1, 0);
        settle();
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_sum", out_sum0, 0);

        // 8 x 5: result visible right after the edge of the 8th accept.
        for (int i = 0; i < 8; i++) send(5, 0, 0, 1);
        settle();
        check("blk5_valid", out_valid0, 1);
        check("blk5_sum", out_sum0, 40);
        check("blk5_count", out_count0, 8);
        check("blk5_sat", out_sat0, 0);

        // 16 + 1984 + 100 + 5 x 0
        send(0, 1, 0, 1); send(15, 7, 0, 1); send(9, 3, 0, 1);
        for (int i = 0; i < 5; i++) send(0, 0, 0, 1);
        settle();
        check("mixed_sum", out_sum0, 2100);
        check("mixed_count", out_count0, 8);

        for (int i = 0; i < 8; i++) send(15, 7, 0, 1);
        settle();
        check("sat12_sum", out_sum1, 4095);
        check("sat12_flag", out_sat1, 1);
        check("sat16_sum", out_sum0, 15872);
        for (int i = 0; i < 8; i++) send(1, 0, 0, 1);
        settle();
        check("after_sat_sum", out_sum1, 8);
        check("after_sat_flag", out_sat1, 0);

        // Flush coinciding with the 4th accept, then flushes on an empty block.
        for (int i = 0; i < 3; i++) send(0, 1, 0, 1);
        send(0, 1, 1, 1);
        settle();
        check("flush_sum", out_sum0, 64);
        check("flush_count", out_count0, 4);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 0);
        settle();
        check("empty_flush_valid", out_valid0, 0);

        // Backpressure: result held for 10 cycles.
        for (int i = 0; i < 8; i++) send(3, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 7, 2, 1, 0, 0);
            settle();
            check("hold_in_ready", in_ready0, 0);
            check("hold_sum", out_sum0, 24);
        end
        cyc(0, 0, 0, 0, 1, 0);
        settle();
        check("release_valid", out_valid0, 0);
        check("release_in_ready", in_ready0, 1);

        // Reset mid-block discards the partial block.
        for (int i = 0; i < 5; i++) send(9, 4, 0, 1);
        cyc(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) send(2, 0, 0, 1);
        settle();
        check("post_rst_sum", out_sum0, 16);
        check("post_rst_count", out_count0, 8);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 7),
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 149) == 0);
        end
        cyc(0, 0, 0, 0, 1, 0);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/minifloat_block_accumulator.md
Name: minifloat_block_accumulator

Overview:
- Downstream consumer of the integer-to-minifloat converter. It takes the converter's 4-bit mantissa and 3-bit exponent outputs, one sample per handshake.
- Each sample is expanded back to an unsigned integer and summed over a fixed-length block. A flush input can close a block early.
- The block sum, sample count and a saturation flag are presented on a registered valid/ready output port. This feeds block-level statistics logic further down the datapath.

Parameters:
- ACC_W, 16, accumulator and output sum width in bits; legal range 11..32.
- BLOCK_LEN, 8, number of samples per block; legal range 1..255.
- CNT_W, 8, width of the sample counter and out_count; must satisfy 2^CNT_W > BLOCK_LEN.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a sample is present on in_m/in_e.
- in_ready  output  1  block can accept a sample this cycle.
- in_m  input  4  sample mantissa (M[3:0] from the converter).
- in_e  input  3  sample exponent (E[2:0] from the converter).
- flush  input  1  close the current block after this cycle.
- out_valid  output  1  result is held on out_sum/out_count/out_sat.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  ACC_W  block sum.
- out_count  output  CNT_W  number of samples in the block.
- out_sat  output  1  the accumulator saturated during the block.

Behaviour:
- Reset is synchronous and active-high, on clk; no asynchronous reset.
- Reset values:
  - state = ACCUM.
  - accumulator = 0, counter = 0, sat flag = 0.
  - out_valid = 0, out_sum = 0, out_count = 0, out_sat = 0.
  - in_ready = 1 on the first cycle after reset deassertion.
- Reset asserted mid-block or while out_valid=1 discards everything. No result is emitted.
- Expansion (combinational):
  - in_e == 0: value = in_m (range 0..15).
  - in_e >= 1: value = {1'b1, in_m} << (in_e − 1).
  - value is 11 bits wide and zero-extended to ACC_W. Maximum value is 31<<6 = 1984.
- Accept: a sample is accepted when in_valid && in_ready. in_ready = (state == ACCUM).
- State ACCUM, on accept:
  - acc_next = acc + value, saturating at 2^ACC_W − 1.
  - sat is set if the unsaturated sum overflows ACC_W; it is sticky for the block.
  - cnt_next = cnt + 1.
- Block close: the block closes when either condition holds:
  - (accept && cnt_next == BLOCK_LEN), or
  - (flush && (cnt_next != 0)), where cnt_next already includes a sample accepted in the same cycle.
- On block close:
  - out_sum, out_count and out_sat are loaded from acc_next, cnt_next and sat_next.
  - out_valid = 1 on the next cycle.
  - State moves to HOLD.
  - Internal acc, cnt and sat clear to 0.
- Latency: exactly 1 cycle from the closing accept (or closing flush) to out_valid.
- flush with zero samples in the block and no accept that cycle is ignored. No empty result is emitted.
- State HOLD:
  - in_ready = 0.
  - flush is ignored.
  - out_* stay stable until out_valid && out_ready.
- On out_valid && out_ready, out_valid drops and state returns to ACCUM on the next cycle. There is no bypass, so the throughput bubble is one cycle per block.
- in_m/in_e are don't-care when in_valid=0. No state changes without an accept, except flush and the output handshake.
- out_valid never drops without out_ready. out_* only change on load or reset.

Test Plan:
- Reset, then 8 samples of (E=0, M=5) with out_ready=1 → one result: out_sum=40, out_count=8, out_sat=0. out_valid rises exactly 1 cycle after the 8th accept.
- Mixed block (E=1,M=0)=16, (E=7,M=15)=1984, (E=3,M=9)=100, then 5×(E=0,M=0) → out_sum=2100, out_count=8, out_sat=0.
- ACC_W=12: 8×(E=7,M=15) → out_sum=4095, out_sat=1. The next block of 8×(E=0,M=1) gives out_sum=8, out_sat=0 (sticky flag cleared).
- 3 samples of value 16, then flush together with a 4th accept of value 16 → out_sum=64, out_count=4. A flush with an empty block produces no output.
- Hold out_ready=0 for 10 cycles after out_valid → in_ready=0 throughout and out_* stable. After out_ready=1: out_valid=0 next cycle, and in_ready=1 the cycle after the handshake.
- Assert rst for one cycle after 5 accepted samples → a new block of 8×(E=0,M=2) yields out_sum=16, out_count=8.
